// File: rtl/exec_pkg.sv
// Shared types and sizing helpers for the execute stage and its iterative multiplier.
package exec_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // Sizing constants depend on the instance parameters, so they are provided as functions.
    function automatic int mul_steps(input int data_width, input int bits_per_cyc);
        return data_width / bits_per_cyc;
    endfunction

    function automatic int fwd_sel_w(input int num_fwd);
        return $clog2(num_fwd + 1);
    endfunction

endpackage

// File: rtl/iter_mul.sv
// Unsigned iterative multiplier retiring BITS_PER_CYC multiplier bits per step.
module iter_mul
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int BITS_PER_CYC = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic                    step_i,
    input  logic                    abort_i,
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic [DATA_WIDTH-1:0]   b_i,
    output logic                    last_o,
    output logic [2*DATA_WIDTH-1:0] product_o
);

    localparam int MUL_STEPS = mul_steps(DATA_WIDTH, BITS_PER_CYC);
    localparam int CNT_W     = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;

    logic [DATA_WIDTH-1:0]              a_q;
    logic [DATA_WIDTH-1:0]              b_q;
    logic [2*DATA_WIDTH-1:0]            acc_q;
    logic [CNT_W-1:0]                   cnt_q;
    logic [DATA_WIDTH+BITS_PER_CYC-1:0] partial;
    logic [2*DATA_WIDTH+BITS_PER_CYC-1:0] sum;

    // Partial product enters at the top and the accumulator shifts right, so after
    // MUL_STEPS steps every partial has landed at its own weight.
    assign partial = {{BITS_PER_CYC{1'b0}}, a_q}
                   * {{DATA_WIDTH{1'b0}}, b_q[BITS_PER_CYC-1:0]};
    assign sum     = {{BITS_PER_CYC{1'b0}}, acc_q} + {partial, {DATA_WIDTH{1'b0}}};

    assign last_o    = (cnt_q == '0);
    assign product_o = acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (abort_i) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= '0;
            cnt_q <= CNT_W'(MUL_STEPS - 1);
        end else if (step_i) begin
            acc_q <= sum[2*DATA_WIDTH+BITS_PER_CYC-1:BITS_PER_CYC];
            b_q   <= b_q >> BITS_PER_CYC;
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: forwarding muxes, ALU, iterative multiply and the registered E->M boundary.
//  state | meaning
//  IDLE  | ALU ops pass through in one cycle; a valid multiply is accepted here
//  MUL   | multiplier stepping; inputs ignored, output register holds
//  DONE  | product ready; commits on the first cycle without stall
module exec_stage
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_FWD        = 2,
    parameter int BITS_PER_CYC   = 8,
    parameter int ALU_CTRL_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_i,
    input  logic                          stall_i,
    input  logic                          flush_i,
    input  logic [ALU_CTRL_WIDTH-1:0]     alu_ctrl_i,
    input  logic                          alu_src_i,
    input  logic                          mul_i,
    input  logic                          mul_hi_i,
    input  logic [DATA_WIDTH-1:0]         rd1_i,
    input  logic [DATA_WIDTH-1:0]         rd2_i,
    input  logic [DATA_WIDTH-1:0]         imm_i,
    input  logic [DATA_WIDTH-1:0]         pc_i,
    input  logic [4:0]                    rd_i,
    input  logic [fwd_sel_w(NUM_FWD)-1:0] fwd_sel_a_i,
    input  logic [fwd_sel_w(NUM_FWD)-1:0] fwd_sel_b_i,
    input  logic [NUM_FWD*DATA_WIDTH-1:0] fwd_data_i,
    output logic [DATA_WIDTH-1:0]         pc_target_o,
    output logic                          zero_o,
    output logic                          busy_o,
    output logic                          valid_o,
    output logic [DATA_WIDTH-1:0]         result_o,
    output logic [DATA_WIDTH-1:0]         write_data_o,
    output logic [4:0]                    rd_o
);

    localparam int FWD_SEL_W = fwd_sel_w(NUM_FWD);
    localparam int SHAMT_W   = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0]   src_a;
    logic [DATA_WIDTH-1:0]   rs2_fwd;
    logic [DATA_WIDTH-1:0]   src_b;
    logic [DATA_WIDTH-1:0]   alu_result;
    logic [SHAMT_W-1:0]      shamt;
    logic [2*DATA_WIDTH-1:0] product;
    logic                    mul_last;

    mul_state_e state_q, state_d;
    logic       mul_start, mul_step, load_alu, load_mul;

    logic [4:0]            rd_lat;
    logic [DATA_WIDTH-1:0] wd_lat;
    logic                  hi_lat;

    // Selects beyond NUM_FWD fall back to the register-file value.
    always_comb begin
        src_a   = rd1_i;
        rs2_fwd = rd2_i;
        for (int k = 1; k <= NUM_FWD; k++) begin
            if (fwd_sel_a_i == FWD_SEL_W'(k)) begin
                src_a = fwd_data_i[(k-1)*DATA_WIDTH +: DATA_WIDTH];
            end
            if (fwd_sel_b_i == FWD_SEL_W'(k)) begin
                rs2_fwd = fwd_data_i[(k-1)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign src_b = alu_src_i ? imm_i : rs2_fwd;
    assign shamt = src_b[SHAMT_W-1:0];

    always_comb begin
        alu_result = '0;
        case (alu_ctrl_i)
            ALU_CTRL_WIDTH'(ALU_ADD):  alu_result = src_a + src_b;
            ALU_CTRL_WIDTH'(ALU_SUB):  alu_result = src_a - src_b;
            ALU_CTRL_WIDTH'(ALU_AND):  alu_result = src_a & src_b;
            ALU_CTRL_WIDTH'(ALU_OR):   alu_result = src_a | src_b;
            ALU_CTRL_WIDTH'(ALU_XOR):  alu_result = src_a ^ src_b;
            ALU_CTRL_WIDTH'(ALU_SLT):
                alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_CTRL_WIDTH'(ALU_SLTU):
                alu_result = {{(DATA_WIDTH-1){1'b0}}, (src_a < src_b)};
            ALU_CTRL_WIDTH'(ALU_SLL):  alu_result = src_a << shamt;
            ALU_CTRL_WIDTH'(ALU_SRL):  alu_result = src_a >> shamt;
            ALU_CTRL_WIDTH'(ALU_SRA):  alu_result = $signed(src_a) >>> shamt;
            default:                   alu_result = '0;
        endcase
    end

    assign pc_target_o = pc_i + imm_i;
    assign zero_o      = (alu_result == '0);

    iter_mul #(
        .DATA_WIDTH   (DATA_WIDTH),
        .BITS_PER_CYC (BITS_PER_CYC)
    ) u_iter_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .step_i    (mul_step),
        .abort_i   (flush_i),
        .a_i       (src_a),
        .b_i       (rs2_fwd),
        .last_o    (mul_last),
        .product_o (product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        mul_step  = 1'b0;
        load_alu  = 1'b0;
        load_mul  = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    load_alu = !stall_i;
                    if (valid_i && mul_i) begin
                        mul_start = 1'b1;
                        state_d   = MUL;
                    end
                end
                MUL: begin
                    mul_step = 1'b1;
                    if (mul_last) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (!stall_i) begin
                        load_mul = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Low on the commit cycle so upstream advances on the same edge as the commit.
    assign busy_o = ((state_q == IDLE) && valid_i && mul_i)
                  || (state_q == MUL)
                  || ((state_q == DONE) && stall_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_lat <= '0;
            wd_lat <= '0;
            hi_lat <= 1'b0;
        end else if (mul_start) begin
            rd_lat <= rd_i;
            wd_lat <= rs2_fwd;
            hi_lat <= mul_hi_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o      <= 1'b0;
            result_o     <= '0;
            write_data_o <= '0;
            rd_o         <= '0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (load_alu) begin
            valid_o      <= valid_i && !mul_i;
            result_o     <= alu_result;
            write_data_o <= rs2_fwd;
            rd_o         <= rd_i;
        end else if (load_mul) begin
            valid_o      <= 1'b1;
            result_o     <= hi_lat ? product[2*DATA_WIDTH-1:DATA_WIDTH] : product[DATA_WIDTH-1:0];
            write_data_o <= wd_lat;
            rd_o         <= rd_lat;
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Directed-vector bench for exec_stage with hand-computed expectations.
module tb_exec_stage;

    logic        clk;
    logic        rst_n;
    logic        valid_i, stall_i, flush_i;
    logic [3:0]  alu_ctrl_i;
    logic        alu_src_i, mul_i, mul_hi_i;
    logic [31:0] rd1_i, rd2_i, imm_i, pc_i;
    logic [4:0]  rd_i;
    logic [1:0]  fwd_sel_a_i, fwd_sel_b_i;
    logic [63:0] fwd_data_i;
    logic [31:0] pc_target_o;
    logic        zero_o, busy_o, valid_o;
    logic [31:0] result_o, write_data_o;
    logic [4:0]  rd_o;

    int n_total = 0;
    int n_bad   = 0;

    exec_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .alu_ctrl_i   (alu_ctrl_i),
        .alu_src_i    (alu_src_i),
        .mul_i        (mul_i),
        .mul_hi_i     (mul_hi_i),
        .rd1_i        (rd1_i),
        .rd2_i        (rd2_i),
        .imm_i        (imm_i),
        .pc_i         (pc_i),
        .rd_i         (rd_i),
        .fwd_sel_a_i  (fwd_sel_a_i),
        .fwd_sel_b_i  (fwd_sel_b_i),
        .fwd_data_i   (fwd_data_i),
        .pc_target_o  (pc_target_o),
        .zero_o       (zero_o),
        .busy_o       (busy_o),
        .valid_o      (valid_o),
        .result_o     (result_o),
        .write_data_o (write_data_o),
        .rd_o         (rd_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (got hang, want finish)");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        valid_i     = 1'b1;
        mul_i       = 1'b0;
        mul_hi_i    = 1'b0;
        alu_src_i   = 1'b0;
        fwd_sel_a_i = 2'd0;
        fwd_sel_b_i = 2'd0;
        alu_ctrl_i  = op;
        rd1_i       = a;
        rd2_i       = b;
    endtask

    task automatic set_mul(input logic hi, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rdv);
        set_alu(4'd0, a, b);
        mul_i    = 1'b1;
        mul_hi_i = hi;
        rd_i     = rdv;
    endtask

    task automatic run_mul(input logic hi, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rdv, input logic [31:0] exp, input string tag);
        int n;
        set_mul(hi, a, b, rdv);
        stall_i = 1'b0;
        #1;
        n = 0;
        while (busy_o && n < 20) begin
            n++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'd5);
        valid_i = 1'b0;
        mul_i   = 1'b0;
        tick();
        chk({tag, "_valid"}, 32'(valid_o), 32'd1);
        chk({tag, "_result"}, result_o, exp);
        chk({tag, "_rd"}, 32'(rd_o), 32'(rdv));
        chk({tag, "_wdata"}, write_data_o, b);
    endtask

    logic [3:0]  t_op [11] = '{4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd1, 4'd0, 4'd6, 4'd5, 4'd5, 4'hF};
    logic [31:0] t_a  [11] = '{32'h0000_F0F0, 32'h0000_F0F0, 32'h0000_F0F0, 32'h1,
                               32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h1,
                               32'hFFFF_FFFF, 32'h5};
    logic [31:0] t_b  [11] = '{32'h0000_FF00, 32'h0000_FF00, 32'h0000_FF00, 32'h21,
                               32'h4, 32'h1, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'h1, 32'h3};
    logic [31:0] t_exp[11] = '{32'h0000_F000, 32'h0000_FFF0, 32'h0000_0FF0, 32'h2,
                               32'h0800_0000, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0,
                               32'h1, 32'h0};

    initial begin
        rst_n       = 1'b0;
        valid_i     = 1'b0;
        stall_i     = 1'b0;
        flush_i     = 1'b0;
        alu_ctrl_i  = 4'd0;
        alu_src_i   = 1'b0;
        mul_i       = 1'b0;
        mul_hi_i    = 1'b0;
        rd1_i       = '0;
        rd2_i       = '0;
        imm_i       = '0;
        pc_i        = '0;
        rd_i        = '0;
        fwd_sel_a_i = '0;
        fwd_sel_b_i = '0;
        fwd_data_i  = '0;

        #12;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_wdata", write_data_o, 32'd0);
        chk("rst_rd", 32'(rd_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // forwarded ADD
        set_alu(4'd0, 32'h0, 32'h5);
        fwd_sel_a_i = 2'd1;
        fwd_data_i  = {32'h0000_0100, 32'h0000_0010};
        rd_i        = 5'd3;
        #1;
        chk("add_fwd_zero", 32'(zero_o), 32'd0);
        tick();
        chk("add_fwd_valid", 32'(valid_o), 32'd1);
        chk("add_fwd_result", result_o, 32'h15);
        chk("add_fwd_rd", 32'(rd_o), 32'd3);
        chk("add_fwd_wdata", write_data_o, 32'h5);

        // SUB with an out-of-range select on A and source 2 on B
        set_alu(4'd1, 32'h1000, 32'h7);
        fwd_sel_a_i = 2'd3;
        fwd_sel_b_i = 2'd2;
        tick();
        chk("sub_fwd_result", result_o, 32'h0000_0F00);
        chk("sub_fwd_wdata", write_data_o, 32'h0000_0100);

        run_mul(1'b0, 32'h0000_FFFF, 32'h0001_0001, 5'd7, 32'hFFFF_FFFF, "mul");
        run_mul(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFE, "mulhu");
        tick();
        chk("post_mul_valid", 32'(valid_o), 32'd0);

        // stall while in DONE
        set_alu(4'd0, 32'h11, 32'h22);
        rd_i = 5'd4;
        tick();
        chk("pre_stall_result", result_o, 32'h33);
        set_mul(1'b0, 32'd3, 32'd5, 5'd9);
        stall_i = 1'b1;
        #1;
        chk("stall_accept_busy", 32'(busy_o), 32'd1);
        tick();
        repeat (4) tick();
        for (int i = 0; i < 3; i++) begin
            chk("stall_done_busy", 32'(busy_o), 32'd1);
            chk("stall_done_valid", 32'(valid_o), 32'd1);
            chk("stall_done_result", result_o, 32'h33);
            tick();
        end
        stall_i = 1'b0;
        valid_i = 1'b0;
        mul_i   = 1'b0;
        #1;
        chk("stall_commit_busy", 32'(busy_o), 32'd0);
        tick();
        chk("stall_commit_valid", 32'(valid_o), 32'd1);
        chk("stall_commit_result", result_o, 32'd15);
        chk("stall_commit_rd", 32'(rd_o), 32'd9);
        chk("stall_commit_wdata", write_data_o, 32'd5);

        // flush in the second MUL cycle
        set_mul(1'b0, 32'd6, 32'd7, 5'd2);
        tick();
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        mul_i   = 1'b0;
        #1;
        chk("flush_valid", 32'(valid_o), 32'd0);
        chk("flush_busy", 32'(busy_o), 32'd0);
        set_alu(4'd0, 32'h20, 32'h22);
        rd_i = 5'd6;
        tick();
        chk("after_flush_valid", 32'(valid_o), 32'd1);
        chk("after_flush_result", result_o, 32'h42);
        set_alu(4'd0, 32'h1, 32'h1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_alu_valid", 32'(valid_o), 32'd0);

        // asynchronous reset mid-multiply
        set_alu(4'd0, 32'h40, 32'h3);
        rd_i = 5'd10;
        tick();
        chk("pre_rst_result", result_o, 32'h43);
        set_mul(1'b0, 32'h1234, 32'h10, 5'd5);
        stall_i = 1'b1;
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(valid_o), 32'd0);
        chk("async_rst_result", result_o, 32'd0);
        chk("async_rst_rd", 32'(rd_o), 32'd0);
        #2;
        rst_n   = 1'b1;
        stall_i = 1'b0;
        run_mul(1'b0, 32'h1234, 32'h10, 5'd5, 32'h0001_2340, "mul_after_rst");

        // SRA by immediate; write data must still be rs2
        set_alu(4'd9, 32'h8000_0000, 32'h0000_ABCD);
        alu_src_i = 1'b1;
        imm_i     = 32'd4;
        pc_i      = 32'h0000_1000;
        #1;
        chk("pc_target", pc_target_o, 32'h0000_1004);
        tick();
        chk("sra_result", result_o, 32'hF800_0000);
        chk("sra_wdata", write_data_o, 32'h0000_ABCD);

        for (int i = 0; i < 11; i++) begin
            set_alu(t_op[i], t_a[i], t_b[i]);
            #1;
            chk($sformatf("alu%0d_zero", i), 32'(zero_o), (t_exp[i] == 32'd0) ? 32'd1 : 32'd0);
            tick();
            chk($sformatf("alu%0d_result", i), result_o, t_exp[i]);
        end

        valid_i = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Parametrised execute stage for the pipelined core. Replaces the fixed two-way forwarding and single-cycle ALU path with three things:
  - NUM_FWD forwarding sources per operand.
  - An iterative multiplier (MUL, MULHU).
  - A registered E→M pipeline boundary with valid, stall and flush.
- Sits between the decode/execute register and the memory stage. busy_o feeds the hazard unit.

Parameters:
- DATA_WIDTH, 32: operand/result width.
- NUM_FWD, 2: number of forwarding sources (M-stage result, W-stage result, ...).
- BITS_PER_CYC, 8: multiplier bits retired per cycle. Must divide DATA_WIDTH.
- ALU_CTRL_WIDTH, 4: width of the ALU op code.

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_i  in  1  instruction present at stage input
- stall_i  in  1  downstream stall; output register holds
- flush_i  in  1  kill stage content (branch mispredict)
- alu_ctrl_i  in  ALU_CTRL_WIDTH  op code (exec_pkg)
- alu_src_i  in  1  0: SrcB = forwarded rs2; 1: SrcB = imm_i
- mul_i  in  1  instruction is a multiply
- mul_hi_i  in  1  0: MUL (low word); 1: MULHU (high word, unsigned)
- rd1_i, rd2_i  in  DATA_WIDTH  register-file operands
- imm_i, pc_i  in  DATA_WIDTH  extended immediate; instruction PC
- rd_i  in  5  destination register
- fwd_sel_a_i, fwd_sel_b_i  in  $clog2(NUM_FWD+1)  forwarding selects
- fwd_data_i  in  NUM_FWD*DATA_WIDTH  forwarding values; source k occupies slice k
- pc_target_o  out  DATA_WIDTH  pc_i + imm_i, combinational
- zero_o  out  1  ALU result == 0, combinational
- busy_o  out  1  stage cannot accept; upstream must hold
- valid_o  out  1  registered M-stage valid
- result_o, write_data_o  out  DATA_WIDTH  registered result; registered forwarded rs2
- rd_o  out  5  registered destination

Behaviour:

Reset:
- valid_o = 0, result_o = 0, write_data_o = 0, rd_o = 0. FSM goes to IDLE, counter = 0.
- Reset mid-multiply discards all multiplier state.

Forwarding:
- Select 0 picks rd1_i/rd2_i. Select k (1..NUM_FWD) picks fwd_data_i slice k-1.
- Select values above NUM_FWD pick the register value.
- write_data_o captures forwarded rs2, never the immediate.

ALU:
- Op codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5 (signed), SLTU=6, SLL=7, SRL=8, SRA=9.
- Shift amount is SrcB[$clog2(DATA_WIDTH)-1:0].
- Undefined codes produce 0.
- Wrap-around modulo 2^DATA_WIDTH.

FSM states: IDLE, MUL, DONE.
- IDLE:
  - If !stall_i, the output register loads: valid_o <= valid_i & !mul_i, plus result, rs2 and rd. This gives 1-cycle latency.
  - If valid_i & mul_i: operands are latched, the 2*DATA_WIDTH accumulator is cleared, counter = N-1 where N = DATA_WIDTH/BITS_PER_CYC, and the FSM goes to MUL. A multiply starts regardless of stall_i. When the multiply starts and !stall_i, valid_o <= 0.
- MUL:
  - Each cycle adds SrcA × the next BITS_PER_CYC bits of SrcB (LSB first), shifted into the accumulator.
  - When counter == 0, go to DONE; otherwise decrement.
  - Output register holds.
- DONE:
  - If !stall_i: result_o <= low or high word per the latched mul_hi_i, valid_o <= 1, rd_o and write_data_o <= latched values, FSM goes to IDLE.
  - Else hold.

busy_o:
- busy_o = (IDLE & valid_i & mul_i) | MUL | (DONE & stall_i), combinational.
- It is low on the commit cycle, so upstream advances on the same edge as the commit and the multiply is never restarted.
- Inputs are ignored while in MUL or DONE.

Timing:
- Multiply result is visible N+2 edges after acceptance when there is no stall. busy_o is high for N+1 cycles.

Flush:
- flush_i has priority over stall_i and over everything except reset.
- Effect: valid_o <= 0 and FSM goes to IDLE, aborting any multiply. Inputs in the flush cycle are not accepted.

Stall in IDLE:
- Output register holds. A valid ALU op is not consumed; upstream holds it under stall_i.

Decomposition:
- exec_pkg holds:
  - alu_op_e enum (codes above).
  - mul_state_e {IDLE, MUL, DONE}.
  - Constants MUL_STEPS = DATA_WIDTH/BITS_PER_CYC and FWD_SEL_W.
- One sub-module, iter_mul:
  - Operand latch, accumulator and counter.
  - start/done handshake plus abort input.
- The ALU and forwarding muxes stay inline.

Test Plan:
1. ADD with fwd_sel_a=1, fwd_data slice0=0x10, rd2=0x5, alu_src=0, valid=1 → next edge: valid_o=1, result_o=0x15. zero_o=0 the same cycle.
2. MUL 0x0000_FFFF × 0x0001_0001, defaults (N=4) → busy_o high 5 cycles; valid_o=1 and result_o=0xFFFF_FFFF on the 6th cycle after acceptance (visible N+2 edges after acceptance). Repeat with MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE.
3. stall_i held 3 cycles while in DONE → result_o and valid_o hold previous values, busy_o stays 1. Commit on the first !stall_i edge, with busy_o low in that cycle.
4. flush_i asserted during the 2nd MUL cycle → next edge: valid_o=0, FSM in IDLE, busy_o=0. A following ADD completes in 1 cycle with the correct value.
5. rst_n pulled low asynchronously mid-MUL → valid_o, result_o and rd_o go to 0 immediately. After release, the first MUL runs the full N steps.
6. SRA 0x8000_0000 by imm 4 (alu_src=1) → 0xF800_0000. SLTU 1 vs 0xFFFF_FFFF → 1. Undefined op 0xF → 0 with zero_o=1.
